// File: rtl/reg_writeback_if.sv
// Writeback bus: two producer result ports, the register-file write port,
// the forwarding lookups and the pending-write scoreboard.
interface reg_writeback_if;
   logic        MEM_VALID;
   logic [4:0]  MEM_RD;
   logic [31:0] MEM_RDV;
   logic        EXEC_VALID;
   logic [4:0]  EXEC_RD;
   logic [31:0] EXEC_RDV;
   logic        IN_READY;
   logic [4:0]  REG_IW_O_A;
   logic [31:0] REG_IW_O_AV;
   logic [4:0]  FW_I_A;
   logic [4:0]  FW_I_B;
   logic        FW_O_AHIT;
   logic [31:0] FW_O_AV;
   logic        FW_O_BHIT;
   logic [31:0] FW_O_BV;
   logic [31:0] PENDING;

   modport master (
      output MEM_VALID, MEM_RD, MEM_RDV, EXEC_VALID, EXEC_RD, EXEC_RDV,
      output FW_I_A, FW_I_B,
      input  IN_READY, REG_IW_O_A, REG_IW_O_AV,
      input  FW_O_AHIT, FW_O_AV, FW_O_BHIT, FW_O_BV, PENDING
   );

   modport slave (
      input  MEM_VALID, MEM_RD, MEM_RDV, EXEC_VALID, EXEC_RD, EXEC_RDV,
      input  FW_I_A, FW_I_B,
      output IN_READY, REG_IW_O_A, REG_IW_O_AV,
      output FW_O_AHIT, FW_O_AV, FW_O_BHIT, FW_O_BV, PENDING
   );
endinterface

// File: rtl/reg_writeback.sv
// Writeback stage: 4-entry in-order FIFO between the load unit / ALU and the
// register-file write port, one write per cycle, with forwarding over every
// uncommitted result (FIFO entries plus the output register).
module reg_writeback (
   input logic           CLK,
   input logic           RST,
   reg_writeback_if.slave bus
);

   logic [4:0]  r_fifo_rd  [4];
   logic [31:0] r_fifo_val [4];
   logic [1:0]  r_wr_ptr;
   logic [1:0]  r_rd_ptr;
   logic [2:0]  r_count;
   logic [4:0]  r_out_a;
   logic [31:0] r_out_av;

   logic        w_in_ready;
   logic        w_mem_en;
   logic        w_exec_en;
   logic        w_pop;
   logic [1:0]  w_push_cnt;
   logic [1:0]  w_exec_slot;
   logic [1:0]  w_slot;
   logic        w_fw_ahit;
   logic [31:0] w_fw_av;
   logic        w_fw_bhit;
   logic [31:0] w_fw_bv;
   logic [31:0] w_pending;

   // Ready only while two free slots remain, so both producers can always push.
   assign w_in_ready  = (r_count <= 3'd2);
   assign w_mem_en    = bus.MEM_VALID  && w_in_ready && (bus.MEM_RD  != 5'd0);
   assign w_exec_en   = bus.EXEC_VALID && w_in_ready && (bus.EXEC_RD != 5'd0);
   assign w_pop       = (r_count != 3'd0);
   assign w_push_cnt  = {1'b0, w_mem_en} + {1'b0, w_exec_en};
   // MEM is the older result when both arrive together.
   assign w_exec_slot = w_mem_en ? (r_wr_ptr + 2'd1) : r_wr_ptr;

   // Pointer, count and output-register update; pop happens before this edge's push.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
         r_out_a  <= 5'd0;
         r_out_av <= 32'd0;
      end else begin
         r_wr_ptr <= r_wr_ptr + w_push_cnt;
         r_count  <= r_count + {1'b0, w_push_cnt} - {2'b00, w_pop};
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
            r_out_a  <= r_fifo_rd[r_rd_ptr];
            r_out_av <= r_fifo_val[r_rd_ptr];
         end else begin
            r_out_a  <= 5'd0;
            r_out_av <= 32'd0;
         end
      end
   end

   // Entry storage; validity comes only from pointers and count, so no reset.
   always_ff @(posedge CLK) begin
      if (!RST && w_mem_en) begin
         r_fifo_rd[r_wr_ptr]  <= bus.MEM_RD;
         r_fifo_val[r_wr_ptr] <= bus.MEM_RDV;
      end
      if (!RST && w_exec_en) begin
         r_fifo_rd[w_exec_slot]  <= bus.EXEC_RD;
         r_fifo_val[w_exec_slot] <= bus.EXEC_RDV;
      end
   end

   // Forwarding and pending mask, walked oldest to youngest so the youngest hit wins.
   always_comb begin
      w_fw_ahit = 1'b0;
      w_fw_av   = 32'd0;
      w_fw_bhit = 1'b0;
      w_fw_bv   = 32'd0;
      w_pending = 32'd0;
      w_slot    = 2'd0;
      w_pending[r_out_a] = 1'b1;
      if (bus.FW_I_A != 5'd0 && r_out_a == bus.FW_I_A) begin
         w_fw_ahit = 1'b1;
         w_fw_av   = r_out_av;
      end
      if (bus.FW_I_B != 5'd0 && r_out_a == bus.FW_I_B) begin
         w_fw_bhit = 1'b1;
         w_fw_bv   = r_out_av;
      end
      for (int i = 0; i < 4; i++) begin
         w_slot = r_rd_ptr + 2'(i);
         if (3'(i) < r_count) begin
            w_pending[r_fifo_rd[w_slot]] = 1'b1;
            if (bus.FW_I_A != 5'd0 && r_fifo_rd[w_slot] == bus.FW_I_A) begin
               w_fw_ahit = 1'b1;
               w_fw_av   = r_fifo_val[w_slot];
            end
            if (bus.FW_I_B != 5'd0 && r_fifo_rd[w_slot] == bus.FW_I_B) begin
               w_fw_bhit = 1'b1;
               w_fw_bv   = r_fifo_val[w_slot];
            end
         end
      end
      w_pending[0] = 1'b0;
   end

   assign bus.IN_READY    = w_in_ready;
   assign bus.REG_IW_O_A  = r_out_a;
   assign bus.REG_IW_O_AV = r_out_av;
   assign bus.FW_O_AHIT   = w_fw_ahit;
   assign bus.FW_O_AV     = w_fw_av;
   assign bus.FW_O_BHIT   = w_fw_bhit;
   assign bus.FW_O_BV     = w_fw_bv;
   assign bus.PENDING     = w_pending;

endmodule
